// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - SDRAM write master: sequential bank-0 fill in BL4 bursts, yields to refresh at burst ends
module sdram_write #(
    parameter int ROW_LAST = 1,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        flag_wr_end,
    output logic        wr_done,
    output logic        wr_busy,
    output logic [3:0]  wr_cmd,
    output logic [11:0] wr_addr,
    output logic [1:0]  bank_addr,
    output logic [15:0] wr_data,
    input  logic [15:0] wr_src_data,
    output logic        wr_src_rd
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_ACT  = 4'b0011;
    localparam logic [3:0]  CMD_WR   = 4'b0100;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  RCD_LAST = 4'(T_RCD);
    localparam logic [3:0]  RP_LAST  = 4'(T_RP);
    localparam logic [11:0] ROW_END  = 12'(ROW_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACT,
        S_WR,
        S_PRE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] row_q, row_d;
    logic        last_q, last_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        flag_q, flag_d;
    logic        done_q, done_d;

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            col_q   <= 7'd0;
            row_q   <= 12'd0;
            last_q  <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= 12'd0;
            data_q  <= 16'd0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        last_d    = last_q;
        cmd_d     = CMD_NOP;
        addr_d    = addr_q;
        data_d    = data_q;
        flag_d    = 1'b0;
        done_d    = 1'b0;
        wr_req    = 1'b0;
        wr_src_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_trig) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wr_req = 1'b1;
                if (wr_en) begin
                    state_d = S_ACT;
                    cnt_d   = 4'd0;
                end
            end
            S_ACT: begin
                if (cnt_q == 4'd0) begin
                    cmd_d  = CMD_ACT;
                    addr_d = row_q;
                end
                if (cnt_q == RCD_LAST) begin
                    state_d = S_WR;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR: begin
                wr_src_rd = 1'b1;
                data_d    = wr_src_data;
                if (cnt_q == 4'd0) begin
                    cmd_d  = CMD_WR;
                    addr_d = {3'b000, col_q, 2'b00};
                end
                if (cnt_q == 4'd3) begin
                    // Burst boundary: the only point where the fill may leave WR.
                    cnt_d = 4'd0;
                    if (col_q == 7'd127 && row_q == ROW_END) begin
                        state_d = S_PRE;
                        last_d  = 1'b1;
                    end else if (col_q == 7'd127) begin
                        state_d = S_PRE;
                        col_d   = 7'd0;
                        row_d   = row_q + 12'd1;
                    end else if (ref_req) begin
                        state_d = S_PRE;
                        col_d   = col_q + 7'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_PRE: begin
                if (cnt_q == 4'd0) begin
                    cmd_d  = CMD_PRE;
                    addr_d = 12'h400;
                end
                if (cnt_q == RP_LAST) begin
                    cnt_d = 4'd0;
                    if (last_q) begin
                        state_d = S_IDLE;
                        flag_d  = 1'b1;
                        done_d  = 1'b1;
                        col_d   = 7'd0;
                        row_d   = 12'd0;
                        last_d  = 1'b0;
                    end else if (ref_req) begin
                        state_d = S_REQ;
                        flag_d  = 1'b1;
                    end else begin
                        state_d = S_ACT;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_busy     = (state_q != S_IDLE);
    assign wr_cmd      = cmd_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign flag_wr_end = flag_q;
    assign wr_done     = done_q;
    assign bank_addr   = 2'b00;

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
SDRAM write-side master that pairs with the read master and shares the same arbiter and command bus. A `wr_trig` pulse starts a sequential fill of bank 0: rows 0..ROW_LAST, full 512-column pages, burst length 4. Data comes from a show-ahead source such as a FIFO. The block yields to refresh at burst boundaries and resumes at the next unwritten column.

Parameters:
- ROW_LAST, 1: last row written; the fill covers rows 0..ROW_LAST.
- T_RCD, 2: NOP cycles after ACT before the first WR.
- T_RP, 2: NOP cycles after PRE before the next ACT, REQ or IDLE.

Ports:
- sclk, input, 1: system clock; all logic runs on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- wr_trig, input, 1: start pulse; ignored unless the block is in IDLE.
- wr_en, input, 1: arbiter grant for the command bus.
- ref_req, input, 1: refresh pending (level signal from the refresh block).
- wr_req, output, 1: bus request to the arbiter.
- flag_wr_end, output, 1: one-cycle pulse when the bus is released.
- wr_done, output, 1: one-cycle pulse when the whole fill is complete.
- wr_busy, output, 1: high whenever state is not IDLE.
- wr_cmd, output, 4: {CS_n, RAS_n, CAS_n, WE_n}. NOP=0111, ACT=0011, WR=0100, PRE=0010.
- wr_addr, output, 12: SDRAM A[11:0].
- bank_addr, output, 2: constant 2'b00.
- wr_data, output, 16: DQ write data.
- wr_src_data, input, 16: show-ahead source word.
- wr_src_rd, output, 1: source pop strobe.

Behaviour:
- Reset (synchronous; applies mid-operation as well, taking effect on the next edge):
  - state=IDLE, wr_cmd=NOP, wr_addr=0, wr_data=0.
  - wr_req, flag_wr_end, wr_done, wr_src_rd all 0.
  - row_cnt=0, col_cnt=0.
- Registered outputs: wr_cmd, wr_addr, wr_data, flag_wr_end and wr_done are registered. wr_req, wr_busy and wr_src_rd are combinational from state and counters.
- Address counters:
  - col_cnt is 7 bits (burst index). Column = {col_cnt, 2'b00}.
  - row_cnt is 12 bits.
  - Counters persist across refresh interruptions and clear to 0 when the fill completes.
- IDLE: on wr_trig=1, go to REQ.
- REQ: wr_req=1. On wr_en=1, go to ACT. Waiting in REQ is unbounded.
- ACT:
  - Cycle 0: wr_cmd=ACT, wr_addr=row_cnt.
  - Next T_RCD cycles: wr_cmd=NOP.
  - Then go to WR.
- WR, bursts of 4 beats with index b=0..3:
  - b=0: wr_cmd=WR, wr_addr={3'b000, col_cnt, 2'b00}, A10=0 (no auto-precharge).
  - b=1..3: wr_cmd=NOP.
  - wr_data shows beat b on each of the 4 cycles.
  - wr_src_rd is high in each cycle whose edge loads wr_data from wr_src_data. Each beat consumes exactly one source word, so there are 4 pops per burst.
  - Outside WR, wr_data holds its last value and wr_src_rd=0.
- Decision at the b=3 edge, evaluated in priority order:
  1. col_cnt=127 and row_cnt=ROW_LAST: fill complete; go to PRE.
  2. col_cnt=127: page end; go to PRE, then ACT on row_cnt+1 with col_cnt=0.
  3. ref_req=1: go to PRE; col_cnt increments.
  4. Otherwise: next burst back-to-back, col_cnt+1.
- PRE:
  - Cycle 0: wr_cmd=PRE, wr_addr=12'h400 (A10=1, all banks).
  - Next T_RP cycles: wr_cmd=NOP.
  - Exit priority: complete, then refresh, then page end.
  - Complete: go to IDLE; flag_wr_end=1 and wr_done=1 for one cycle; counters clear.
  - Refresh: go to REQ; flag_wr_end=1 for one cycle.
  - Page end: go to ACT without releasing the bus.
- Mid-burst refresh: a ref_req arriving at b<3 never truncates the burst; it is honoured at that burst's b=3 edge.
- ref_req and page end together: take the page-end precharge. The PRE exit then goes to REQ (refresh has priority over re-ACT), and the next ACT uses the incremented row.
- wr_trig while busy: ignored, with no effect on counters.
- No underflow check: the source must be non-empty during WR.

Test Plan:
- Basic single page, ROW_LAST=0: pulse wr_trig, hold wr_en=1, source = incrementing 0..511.
  - Command sequence: ACT(row 0), 2 NOP, 128 WR commands at columns 0,4,...,508, PRE with addr 0x400.
  - Exactly 512 wr_src_rd pulses; wr_data runs 0..511 with no gaps.
  - wr_done and flag_wr_end pulse once; block returns to IDLE.
- Page crossing, ROW_LAST=1:
  - After column 508 of row 0: PRE, 2 NOP, ACT with wr_addr=1, then WR at column 0.
  - 1024 words total; wr_done pulses once.
- Refresh mid-burst: assert ref_req at b=1 of the burst at column 40.
  - Burst completes (4 beats), then PRE, then flag_wr_end pulse, then wr_req=1.
  - After regrant: ACT row 0, first WR at column 44, no word lost or duplicated.
- Grant delay: hold wr_en=0 for 10 cycles in REQ.
  - wr_req stays 1 and wr_cmd stays NOP until the grant arrives.
- Reset mid-WR: assert reset at b=2 of column 100.
  - Next cycle: all outputs at reset values, state IDLE.
  - A fresh wr_trig restarts at row 0, column 0.
- Ignored trigger: pulse wr_trig during WR; no second fill starts after wr_done.
